// File: rtl/net_stream_host.sv
// Host endpoint for the FC network stream: sends one stored input vector, collects the
// result vector into a readable buffer, and reports completion plus transaction latency.
module net_stream_host #(
  parameter int IN_N  = 4,
  parameter int OUT_N = 16,
  parameter int T     = 16,
  parameter int CW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  input  logic [$clog2(IN_N)-1:0]    ld_addr,
  input  logic signed [T-1:0]        ld_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [CW-1:0]              cycles,
  input  logic [$clog2(OUT_N)-1:0]   rd_addr,
  output logic signed [T-1:0]        rd_data,
  output logic                       net_in_valid,
  input  logic                       net_in_ready,
  output logic signed [T-1:0]        net_in_data,
  input  logic                       net_out_valid,
  output logic                       net_out_ready,
  input  logic signed [T-1:0]        net_out_data
);

  localparam int IA = $clog2(IN_N);
  localparam int OA = $clog2(OUT_N);
  localparam int SW = $clog2(IN_N + 1);
  localparam int RW = $clog2(OUT_N + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [SW-1:0] SEND_FULL = SW'(IN_N);
  localparam logic [RW-1:0] RECV_FULL = RW'(OUT_N);
  localparam logic [IA:0]   IN_LIM    = (IA + 1)'(IN_N);
  localparam logic [OA:0]   OUT_LIM   = (OA + 1)'(OUT_N);
  localparam logic [CW-1:0] CYC_MAX   = {CW{1'b1}};

  logic [1:0]          state_r;
  logic [SW-1:0]       send_cnt_r;
  logic [RW-1:0]       recv_cnt_r;
  logic [CW-1:0]       cycles_r;
  logic signed [T-1:0] inbuf_r  [IN_N];
  logic signed [T-1:0] outbuf_r [OUT_N];

  logic in_busy_s;
  logic send_left_s;
  logic recv_left_s;
  logic in_fire_s;
  logic out_fire_s;

  assign in_busy_s   = (state_r == ST_BUSY);
  assign send_left_s = (send_cnt_r < SEND_FULL);
  assign recv_left_s = (recv_cnt_r < RECV_FULL);
  assign in_fire_s   = net_in_valid && net_in_ready;
  assign out_fire_s  = net_out_valid && net_out_ready;

  assign busy   = in_busy_s;
  assign done   = (state_r == ST_DONE);
  assign cycles = cycles_r;

  // Stream strobes are decoded from registered state so they never glitch mid-word.
  always_comb begin
    net_in_valid  = 1'b0;
    net_in_data   = {T{1'b0}};
    net_out_ready = 1'b0;
    if (in_busy_s && send_left_s) begin
      net_in_valid = 1'b1;
      net_in_data  = inbuf_r[send_cnt_r[IA-1:0]];
    end else begin
      net_in_valid = 1'b0;
      net_in_data  = {T{1'b0}};
    end
    if (in_busy_s && recv_left_s) begin
      net_out_ready = 1'b1;
    end else begin
      net_out_ready = 1'b0;
    end
  end

  // Result read port; out-of-range addresses read as zero.
  always_comb begin
    rd_data = {T{1'b0}};
    if ({1'b0, rd_addr} < OUT_LIM) begin
      rd_data = outbuf_r[rd_addr];
    end else begin
      rd_data = {T{1'b0}};
    end
  end

  // Transaction FSM, transfer counters and saturating latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      send_cnt_r <= {SW{1'b0}};
      recv_cnt_r <= {RW{1'b0}};
      cycles_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_BUSY;
            send_cnt_r <= {SW{1'b0}};
            recv_cnt_r <= {RW{1'b0}};
            cycles_r   <= {CW{1'b0}};
          end
        end
        ST_BUSY: begin
          if (cycles_r != CYC_MAX) begin
            cycles_r <= cycles_r + {{(CW-1){1'b0}}, 1'b1};
          end
          if (in_fire_s) begin
            send_cnt_r <= send_cnt_r + {{(SW-1){1'b0}}, 1'b1};
          end
          if (out_fire_s) begin
            recv_cnt_r <= recv_cnt_r + {{(RW-1){1'b0}}, 1'b1};
          end
          // Completion is judged on settled counters, one cycle after the last transfer.
          if (!send_left_s && !recv_left_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Input and result buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IN_N; i++) begin
        inbuf_r[i] <= {T{1'b0}};
      end
      for (int j = 0; j < OUT_N; j++) begin
        outbuf_r[j] <= {T{1'b0}};
      end
    end else begin
      if ((state_r == ST_IDLE) && ld_valid && ({1'b0, ld_addr} < IN_LIM)) begin
        inbuf_r[ld_addr] <= ld_data;
      end
      if (out_fire_s) begin
        outbuf_r[recv_cnt_r[OA-1:0]] <= net_out_data;
      end
    end
  end

endmodule

// File: tb/tb_net_stream_host.sv
// Scoreboard bench for net_stream_host: a behavioural network model drives both streams,
// expected words are queued at stimulus time and popped as the DUT transfers or is read.
module tb_net_stream_host;

  localparam int IN_N  = 4;
  localparam int OUT_N = 16;
  localparam int T     = 16;
  localparam int CW    = 32;
  localparam int BUDGET = 300;

  logic                clk;
  logic                reset;
  logic                ld_valid;
  logic [1:0]          ld_addr;
  logic signed [T-1:0] ld_data;
  logic                start;
  logic                busy;
  logic                done;
  logic [CW-1:0]       cycles;
  logic [3:0]          rd_addr;
  logic signed [T-1:0] rd_data;
  logic                net_in_valid;
  logic                net_in_ready;
  logic signed [T-1:0] net_in_data;
  logic                net_out_valid;
  logic                net_out_ready;
  logic signed [T-1:0] net_out_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit saw_both;

  logic signed [T-1:0] vec [IN_N];
  logic signed [T-1:0] exp_in_q  [$];
  logic signed [T-1:0] exp_out_q [$];

  net_stream_host #(.IN_N(IN_N), .OUT_N(OUT_N), .T(T), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .cycles        (cycles),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .net_in_valid  (net_in_valid),
    .net_in_ready  (net_in_ready),
    .net_in_data   (net_in_data),
    .net_out_valid (net_out_valid),
    .net_out_ready (net_out_ready),
    .net_out_data  (net_out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle_inputs();
    ld_valid      = 1'b0;
    ld_addr       = 2'd0;
    ld_data       = 16'sd0;
    start         = 1'b0;
    net_in_ready  = 1'b0;
    net_out_valid = 1'b0;
    net_out_data  = 16'sd0;
  endtask

  task automatic load_vec();
    for (int i = 0; i < IN_N; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = 2'(i);
      ld_data  = vec[i];
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // pat: 0 = input ready always, 1 = ready pattern 1,0,0 repeating.
  // lat: <0 outputs offered from the first cycle, else LAT cycles after the last input.
  task automatic run_txn(input int pat, input int lat, input int n_emit, input int base,
                         input int abort_at, input bit poke, input int exp_cyc);
    int cyc;
    int in_acc;
    int emitted;
    int lat_cnt;
    bit fin;
    bit in_hs;
    bit out_hs;
    cyc = 0; in_acc = 0; emitted = 0; lat_cnt = 0; fin = 1'b0; saw_both = 1'b0;
    for (int i = 0; i < IN_N; i++) exp_in_q.push_back(vec[i]);
    for (int k = 0; k < OUT_N; k++) exp_out_q.push_back(16'(base + k));
    @(negedge clk);
    start = 1'b1;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start    = poke && (cyc >= 2);
      ld_valid = poke && (cyc == 2);
      ld_addr  = 2'd3;
      ld_data  = 16'sd77;
      if (done) begin
        if (exp_cyc >= 0) check_val("cycles_at_done", cycles, exp_cyc);
        check_val("done_busy_low", busy, 0);
        check_val("done_in_valid_low", net_in_valid, 0);
        check_val("done_out_ready_low", net_out_ready, 0);
        fin = 1'b1;
      end else begin
        net_in_ready = (pat == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
        if (lat >= 0 && in_acc == IN_N) lat_cnt++;
        if ((lat < 0 || (in_acc == IN_N && lat_cnt >= lat)) && emitted < n_emit) begin
          net_out_valid = 1'b1;
          net_out_data  = 16'(base + emitted);
        end else begin
          net_out_valid = 1'b0;
          net_out_data  = 16'sd0;
        end
        if (in_acc < IN_N) check_val("in_valid_held", net_in_valid, 1);
        in_hs  = net_in_valid && net_in_ready;
        out_hs = net_out_valid && net_out_ready;
        if (in_hs) begin
          if (exp_in_q.size() > 0) check_val("in_data", net_in_data, exp_in_q.pop_front());
          in_acc++;
        end else if (net_in_valid && exp_in_q.size() > 0) begin
          check_val("in_stall_data", net_in_data, exp_in_q[0]);
        end
        if (net_out_valid && emitted >= OUT_N) check_val("ready_after_full", net_out_ready, 0);
        if (out_hs) emitted++;
        if (in_hs && out_hs) saw_both = 1'b1;
        if (abort_at > 0 && in_acc == abort_at) fin = 1'b1;
      end
    end
    if (!fin) check_val("timeout_done", done, 1);
    if (abort_at > 0) return;
    check_val("n_sent", in_acc, IN_N);
    @(negedge clk);
    start = 1'b0;
    ld_valid = 1'b0;
    net_in_ready = 1'b0;
    check_val("done_one_cycle", done, 0);
    check_val("idle_busy_low", busy, 0);
    if (n_emit > OUT_N) check_val("extra_beat_ready", net_out_ready, 0);
    if (exp_cyc >= 0) check_val("cycles_hold", cycles, exp_cyc);
    net_out_valid = 1'b0;
    net_out_data  = 16'sd0;
    for (int k = 0; k < OUT_N; k++) begin
      rd_addr = 4'(k);
      #1;
      if (exp_out_q.size() > 0) check_val("outbuf", rd_data, exp_out_q.pop_front());
    end
    rd_addr = 4'd0;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = 4'd0;
    idle_inputs();
    #12;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_cycles", cycles, 0);
    check_val("rst_in_valid", net_in_valid, 0);
    check_val("rst_out_ready", net_out_ready, 0);
    check_val("rst_in_data", net_in_data, 0);
    check_val("rst_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // Echo model, everything ready: 16 outputs in cycles 1..16, one settle cycle.
    vec = '{16'sd1, -16'sd2, 16'sd3, -16'sd4};
    load_vec();
    run_txn(0, -1, 16, 0, 0, 1'b0, 17);

    // Input ready 1,0,0: sends land in cycles 1,4,7,10; outputs 11..26.
    vec = '{16'sd10, -16'sd20, 16'sd30, -16'sd40};
    load_vec();
    run_txn(1, 0, 16, 50, 0, 1'b0, 27);

    // Outputs stream while inputs are still being sent.
    vec = '{16'sd5, 16'sd6, -16'sd7, 16'sd8};
    load_vec();
    run_txn(1, -1, 16, -8, 0, 1'b0, 17);
    check_val("both_same_cycle", saw_both, 1);

    // Latency 5: sends 1..4, outputs 9..24, settle cycle 25; start/ld poked while busy.
    vec = '{16'sd100, -16'sd100, 16'sd200, -16'sd200};
    load_vec();
    run_txn(0, 5, 16, 200, 0, 1'b1, 25);

    // Reset after two sends aborts everything; a fresh transaction restarts at word 0.
    vec = '{16'sd9, 16'sd8, 16'sd7, 16'sd6};
    load_vec();
    run_txn(0, -1, 16, 0, 2, 1'b0, -1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_in_valid", net_in_valid, 0);
    check_val("abort_in_data", net_in_data, 0);
    check_val("abort_out_ready", net_out_ready, 0);
    check_val("abort_cycles", cycles, 0);
    check_val("abort_rd_data", rd_data, 0);
    exp_in_q.delete();
    exp_out_q.delete();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    load_vec();
    run_txn(0, -1, 16, 400, 0, 1'b0, 17);

    // Model offers a 17th beat that must be refused.
    vec = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
    load_vec();
    run_txn(0, -1, 17, 300, 0, 1'b0, 17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
